// File: rtl/param_store_buffer.sv
// -----------------------------------------------------------------------------
// param_store_buffer
//   In-order store buffer between the LSU and the D-cache / uncached write
//   paths. Speculative stores are held until the ROB commits them (up to
//   COMMIT_W per cycle). Uncommitted stores are discarded on rollback.
//   Committed stores drain oldest-first to the D-cache accessor or to the
//   uncached handler.
//
// Ports
//   clk, resetn             clock, async active-low reset
//   enq_*                   store allocation from the LSU (valid/ready handshake)
//   com_cnt                 number of stores the ROB commits this cycle
//   rb                      rollback: drop every uncommitted store
//   dc_req/addr/data/size   cached write request for the head entry
//   dc_ack, dc_done         D-cache issued / completed the head write
//   dc_refill, dc_refill_line  refill in progress and its line address [31:4]
//   uc_req/addr/data/size   uncached write request for the head entry
//   uc_ready                uncached handler accepted and completed the write
//   q_addr, q_cache         read-buffer dependency query
//   rely                    per-entry dependency of the query
//   cur                     per-entry valid
//   occ, half_o             registered occupancy and half-full flag
// -----------------------------------------------------------------------------
module param_store_buffer #(
    parameter int DEPTH       = 16,
    parameter int COMMIT_W    = 2,
    parameter int ID_W        = 7,
    parameter int HALF_THRESH = 6,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(COMMIT_W + 1),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [31:0]       enq_addr,
    input  logic [31:0]       enq_data,
    input  logic [1:0]        enq_size,
    input  logic [ID_W-1:0]   enq_id,
    input  logic              enq_cache,
    input  logic [CNT_W-1:0]  com_cnt,
    input  logic              rb,
    output logic              dc_req,
    output logic [31:0]       dc_addr,
    output logic [31:0]       dc_data,
    output logic [1:0]        dc_size,
    input  logic              dc_ack,
    input  logic              dc_done,
    input  logic              dc_refill,
    input  logic [27:0]       dc_refill_line,
    output logic              uc_req,
    output logic [31:0]       uc_addr,
    output logic [31:0]       uc_data,
    output logic [1:0]        uc_size,
    input  logic              uc_ready,
    input  logic [31:0]       q_addr,
    input  logic              q_cache,
    output logic [DEPTH-1:0]  rely,
    output logic [DEPTH-1:0]  cur,
    output logic [OCC_W-1:0]  occ,
    output logic              half_o
);

    // Control state (reset) and payload (not reset).
    logic [DEPTH-1:0]           valid, com, issued, cache_q;
    logic [31:0]                addr_q [DEPTH];
    logic [31:0]                data_q [DEPTH];
    logic [1:0]                 size_q [DEPTH];
    logic [DEPTH-1:0][ID_W-1:0] id_q;
    logic [PTR_W-1:0]           wp, cp, fp;

    logic             do_enq, eligible, clash, free;
    logic [CNT_W-1:0] avail, k;
    logic [DEPTH-1:0] com_set, roll_mask, valid_n, com_n, issued_n;
    logic [OCC_W-1:0] roll_cnt, occ_n;
    logic             half_n;
    logic [PTR_W-1:0] idx;
    logic             run;
    int               occ_sum;

    // ROB ids travel with each entry but no port reads them back; the query
    // byte offset is irrelevant because dependencies are tracked per word.
    logic unused_bits;
    assign unused_bits = ^{id_q, q_addr[1:0]};

    // enq_ready looks at the pre-edge valid bit, so a slot freed this cycle
    // is only reusable next cycle.
    assign enq_ready = ~valid[wp] & ~rb;
    assign do_enq    = enq_valid & enq_ready;

    // Head of the drain queue.
    assign eligible = valid[fp] & com[fp] & ~issued[fp];
    assign dc_req   = eligible & cache_q[fp];
    assign uc_req   = eligible & ~cache_q[fp];
    assign dc_addr  = addr_q[fp];
    assign dc_data  = data_q[fp];
    assign dc_size  = size_q[fp];
    assign uc_addr  = addr_q[fp];
    assign uc_data  = data_q[fp];
    assign uc_size  = size_q[fp];

    // A refill of the head's line invalidates an in-flight write; it must be
    // re-requested, so the clash wins over a same-cycle ack.
    assign clash = dc_refill & valid[fp] & cache_q[fp] & ~dc_done &
                   (dc_refill_line == addr_q[fp][31:4]);
    assign free  = (dc_done & valid[fp] & cache_q[fp]) | (uc_req & uc_ready);

    // Commit window: count contiguous valid & uncommitted entries from cp,
    // clamp the request to it, and mark those entries.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments so later
        // statements see earlier results (the loop accumulators rely on it);
        // clocked blocks use non-blocking so all state updates together.
        // NOTE: every variable gets a default before any conditional write,
        // otherwise a path that skips the assignment infers a latch.
        avail   = '0;
        run     = 1'b1;
        idx     = cp;
        com_set = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            idx = cp + PTR_W'(j);
            if (run && valid[idx] && !com[idx]) avail = avail + CNT_W'(1);
            else                                run   = 1'b0;
        end
        k = (com_cnt < avail) ? com_cnt : avail;
        if (rb) k = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            if (CNT_W'(j) < k) com_set[cp + PTR_W'(j)] = 1'b1;
        end
    end

    // Next-state per-entry flags and occupancy.
    always_comb begin
        valid_n  = valid;
        com_n    = com | com_set;
        issued_n = issued;
        if (do_enq) begin
            valid_n[wp]  = 1'b1;
            com_n[wp]    = 1'b0;
            issued_n[wp] = 1'b0;
        end
        if (clash)                issued_n[fp] = 1'b0;
        else if (dc_req && dc_ack) issued_n[fp] = 1'b1;
        if (free) begin
            valid_n[fp]  = 1'b0;
            com_n[fp]    = 1'b0;
            issued_n[fp] = 1'b0;
        end

        // An entry being freed is not also counted as rolled back.
        roll_mask = rb ? (valid & ~com) : '0;
        if (free) roll_mask[fp] = 1'b0;
        valid_n = valid_n & ~roll_mask;

        roll_cnt = '0;
        for (int i = 0; i < DEPTH; i++) roll_cnt = roll_cnt + OCC_W'(roll_mask[i]);

        occ_sum = int'(occ) + int'(do_enq) - int'(free) - int'(roll_cnt);
        if (occ_sum < 0)     occ_sum = 0;
        if (occ_sum > DEPTH) occ_sum = DEPTH;
        occ_n  = OCC_W'(occ_sum);
        half_n = (occ_sum >= HALF_THRESH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid  <= '0;
            com    <= '0;
            issued <= '0;
            wp     <= '0;
            cp     <= '0;
            fp     <= '0;
            occ    <= '0;
            half_o <= 1'b0;
        end else begin
            valid  <= valid_n;
            com    <= com_n;
            issued <= issued_n;
            wp     <= rb ? cp : wp + PTR_W'(do_enq);
            cp     <= cp + PTR_W'(k);
            fp     <= fp + PTR_W'(free);
            occ    <= occ_n;
            half_o <= half_n;
        end
    end

    // NOTE: the payload array is deliberately left out of reset; nothing
    // reads a field unless its valid bit is set, and skipping the reset
    // lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            addr_q[wp]  <= enq_addr;
            data_q[wp]  <= enq_data;
            size_q[wp]  <= enq_size;
            id_q[wp]    <= enq_id;
            cache_q[wp] <= enq_cache;
        end
    end

    // Read-buffer dependency: same word for cached queries, any uncached
    // store for uncached queries.
    always_comb begin
        rely = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_cache) rely[i] = valid[i] & cache_q[i] & (addr_q[i][31:2] == q_addr[31:2]);
            else         rely[i] = valid[i] & ~cache_q[i];
        end
    end

    assign cur = valid;

endmodule

// File: tb/tb_param_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_param_store_buffer
//   Directed bench for param_store_buffer. A queue-based model of the store
//   buffer (ordered list of stores with committed/issued flags and the slot
//   each one occupies) predicts every output; a negedge process compares the
//   DUT against it every cycle, and each scenario also checks hand-computed
//   literal values.
// -----------------------------------------------------------------------------
module tb_param_store_buffer;

    localparam int DEPTH       = 16;
    localparam int COMMIT_W    = 2;
    localparam int ID_W        = 7;
    localparam int HALF_THRESH = 6;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enq_valid, enq_ready, enq_cache, rb;
    logic [31:0] enq_addr, enq_data;
    logic [1:0]  enq_size;
    logic [ID_W-1:0] enq_id;
    logic [1:0]  com_cnt;
    logic        dc_req, dc_ack, dc_done, dc_refill;
    logic [31:0] dc_addr, dc_data;
    logic [1:0]  dc_size;
    logic [27:0] dc_refill_line;
    logic        uc_req, uc_ready;
    logic [31:0] uc_addr, uc_data;
    logic [1:0]  uc_size;
    logic [31:0] q_addr;
    logic        q_cache;
    logic [DEPTH-1:0] rely, cur;
    logic [4:0]  occ;
    logic        half_o;

    always #5 clk = ~clk;

    param_store_buffer #(
        .DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .ID_W(ID_W), .HALF_THRESH(HALF_THRESH)
    ) dut (
        .clk(clk), .resetn(resetn),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
        .enq_data(enq_data), .enq_size(enq_size), .enq_id(enq_id),
        .enq_cache(enq_cache), .com_cnt(com_cnt), .rb(rb),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_data(dc_data), .dc_size(dc_size),
        .dc_ack(dc_ack), .dc_done(dc_done), .dc_refill(dc_refill),
        .dc_refill_line(dc_refill_line),
        .uc_req(uc_req), .uc_addr(uc_addr), .uc_data(uc_data), .uc_size(uc_size),
        .uc_ready(uc_ready), .q_addr(q_addr), .q_cache(q_cache),
        .rely(rely), .cur(cur), .occ(occ), .half_o(half_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        cache;
        logic        com;
        logic        issued;
        int          slot;
    } st_t;

    st_t         mq[$];          // oldest first
    int          alloc_slot;     // slot the next store will occupy
    int          commit_slot;    // slot of the next store to be committed
    bit          chk_en = 1'b0;
    logic [31:0] dut_log[$];     // addresses of completed cached writes

    task automatic model_step();
        st_t h;
        int  ncom, k, avail;
        bit  enq_ok, freed;
        enq_ok = (mq.size() < DEPTH) && !rb;
        ncom = 0;
        foreach (mq[i]) if (mq[i].com) ncom++;
        freed = 1'b0;
        if (mq.size() > 0) begin
            h = mq[0];
            if (h.cache) begin
                if (dc_done) freed = 1'b1;
                else if (dc_refill && dc_refill_line == h.addr[31:4]) h.issued = 1'b0;
                else if (h.com && !h.issued && dc_ack) h.issued = 1'b1;
            end else if (h.com && uc_ready) begin
                freed = 1'b1;
            end
            mq[0] = h;
        end
        if (!rb) begin
            k     = int'(com_cnt);
            avail = mq.size() - ncom;
            if (k > avail) begin
                fails++;
                $display("FAIL commit_overrun: com_cnt %0d, available %0d", k, avail);
                k = avail;
            end
            for (int i = ncom; i < ncom + k; i++) begin
                h = mq[i];
                h.com = 1'b1;
                mq[i] = h;
            end
            commit_slot = (commit_slot + k) % DEPTH;
        end
        if (freed) void'(mq.pop_front());
        if (rb) begin
            while (mq.size() > 0 && !mq[mq.size()-1].com) void'(mq.pop_back());
            alloc_slot = commit_slot;
        end
        if (enq_valid && enq_ok) begin
            h.addr   = enq_addr;
            h.data   = enq_data;
            h.size   = enq_size;
            h.cache  = enq_cache;
            h.com    = 1'b0;
            h.issued = 1'b0;
            h.slot   = alloc_slot;
            mq.push_back(h);
            alloc_slot = (alloc_slot + 1) % DEPTH;
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            alloc_slot  = 0;
            commit_slot = 0;
        end else begin
            model_step();
        end
    end

    // -------------------------------------------------------------- compare
    always @(negedge clk) begin
        logic [DEPTH-1:0] cur_e, rely_e;
        bit   dreq, ureq;
        st_t  h;
        if (chk_en) begin
            cur_e  = '0;
            rely_e = '0;
            foreach (mq[i]) begin
                cur_e[mq[i].slot] = 1'b1;
                if (q_cache ? (mq[i].cache && mq[i].addr[31:2] == q_addr[31:2]) : !mq[i].cache)
                    rely_e[mq[i].slot] = 1'b1;
            end
            dreq = 1'b0;
            ureq = 1'b0;
            if (mq.size() > 0) begin
                h    = mq[0];
                dreq = h.com && !h.issued && h.cache;
                ureq = h.com && !h.issued && !h.cache;
            end
            check("enq_ready", enq_ready, (mq.size() < DEPTH) && !rb);
            check("dc_req", dc_req, dreq);
            check("uc_req", uc_req, ureq);
            if (dreq) begin
                check("dc_addr", dc_addr, h.addr);
                check("dc_data", dc_data, h.data);
                check("dc_size", dc_size, h.size);
            end
            if (ureq) begin
                check("uc_addr", uc_addr, h.addr);
                check("uc_data", uc_data, h.data);
                check("uc_size", uc_size, h.size);
            end
            check("cur", cur, cur_e);
            check("rely", rely, rely_e);
            check("occ", occ, mq.size());
            check("half_o", half_o, mq.size() >= HALF_THRESH);
            if (dc_req && dc_done) dut_log.push_back(dc_addr);
        end
    end

    // ------------------------------------------------------------- stimulus
    logic [ID_W-1:0] id_ctr = '0;

    task automatic idle();
        enq_valid      = 1'b0;
        enq_addr       = '0;
        enq_data       = '0;
        enq_size       = '0;
        enq_id         = '0;
        enq_cache      = 1'b0;
        com_cnt        = '0;
        rb             = 1'b0;
        dc_ack         = 1'b0;
        dc_done        = 1'b0;
        dc_refill      = 1'b0;
        dc_refill_line = '0;
        uc_ready       = 1'b0;
    endtask

    // Advance one clock; inputs return to idle just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1 idle();
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic c);
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
        enq_size  = s;
        enq_cache = c;
        enq_id    = id_ctr;
        id_ctr    = id_ctr + 1'b1;
        cycle();
    endtask

    // D-cache that acks and completes whatever the buffer requests.
    task automatic respond_cycle();
        #1;
        dc_ack  = dc_req;
        dc_done = dc_req;
        cycle();
    endtask

    initial begin
        int hi;
        bit dc_any;
        idle();
        q_addr  = '0;
        q_cache = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        #1;

        // Reset state
        check("rst_enq_ready", enq_ready, 1'b1);
        check("rst_occ", occ, 0);
        check("rst_half", half_o, 1'b0);
        check("rst_dc_req", dc_req, 1'b0);
        check("rst_uc_req", uc_req, 1'b0);
        check("rst_cur", cur, 16'h0000);
        chk_en = 1'b1;

        // 1: fill with 16 uncommitted cached stores
        for (int i = 0; i < 16; i++) enq(32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd2, 1'b1);
        check("t1_enq_ready", enq_ready, 1'b0);
        check("t1_occ", occ, 16);
        check("t1_half", half_o, 1'b1);
        check("t1_dc_req", dc_req, 1'b0);
        check("t1_cur", cur, 16'hFFFF);
        enq(32'hDEAD_0000, 32'h1, 2'd2, 1'b1);   // rejected while full
        check("t1_full_occ", occ, 16);
        rb = 1'b1;
        #1 check("t1_rb_enq_ready", enq_ready, 1'b0);
        cycle();
        check("t1_flush_occ", occ, 0);
        check("t1_flush_cur", cur, 16'h0000);

        // 2: four stores, commit 2+2, drained in order
        for (int i = 0; i < 4; i++) enq(32'h100 + 32'(4 * i), 32'hB0 + 32'(i), 2'(i % 3), 1'b1);
        dut_log.delete();
        for (int c = 0; c < 6; c++) begin
            if (c < 2) com_cnt = 2'd2;
            respond_cycle();
        end
        check("t2_writes", dut_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < dut_log.size()) check("t2_write_addr", dut_log[i], 32'h100 + 32'(4 * i));
        check("t2_occ", occ, 0);

        // 3: six stores, commit 2, rollback the other 4 (slots 4..9)
        for (int i = 0; i < 6; i++) enq(32'h300 + 32'(4 * i), 32'hC0 + 32'(i), 2'd2, 1'b1);
        check("t3_cur_pre", cur, 16'h03F0);
        com_cnt = 2'd2;
        cycle();
        rb = 1'b1;
        cycle();
        check("t3_cur_rb", cur, 16'h0030);
        check("t3_occ_rb", occ, 2);
        enq(32'h3F0, 32'hCF, 2'd2, 1'b1);       // lands at slot 6 (wp == cp)
        check("t3_cur_realloc", cur, 16'h0070);
        rb = 1'b1;
        cycle();
        for (int c = 0; c < 3; c++) respond_cycle();
        check("t3_occ_drained", occ, 0);

        // 4: refill clash on an issued head
        enq(32'h2004, 32'hC0DE, 2'd2, 1'b1);
        com_cnt = 2'd1;
        cycle();
        check("t4_req_first", dc_req, 1'b1);
        dc_ack = 1'b1;
        cycle();
        check("t4_req_issued", dc_req, 1'b0);
        dc_refill      = 1'b1;
        dc_refill_line = 28'h201;               // other line: no effect
        cycle();
        check("t4_req_other_line", dc_req, 1'b0);
        dc_refill      = 1'b1;
        dc_refill_line = 28'h200;
        cycle();
        check("t4_req_reissue", dc_req, 1'b1);
        check("t4_occ_held", occ, 1);
        dc_ack  = 1'b1;
        dc_done = 1'b1;
        cycle();
        check("t4_occ_done", occ, 0);
        check("t4_req_done", dc_req, 1'b0);

        // 5: uncached store held off for 5 cycles
        enq(32'h8000, 32'h55, 2'd0, 1'b0);
        com_cnt = 2'd1;
        cycle();
        hi     = 0;
        dc_any = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (uc_req) hi++;
            if (dc_req) dc_any = 1'b1;
            cycle();
        end
        check("t5_uc_req_cycles", hi, 5);
        uc_ready = 1'b1;
        #1 check("t5_uc_req_ready", uc_req, 1'b1);
        cycle();
        check("t5_occ", occ, 0);
        check("t5_uc_req_after", uc_req, 1'b0);
        check("t5_dc_never", dc_any, 1'b0);

        // 6: dependency query (slots 8 and 9)
        enq(32'h40, 32'h1, 2'd2, 1'b1);
        enq(32'h80, 32'h2, 2'd2, 1'b0);
        q_addr  = 32'h42;
        q_cache = 1'b1;
        #1 check("t6_rely_cached", rely, 16'h0100);
        q_cache = 1'b0;
        #1 check("t6_rely_uncached", rely, 16'h0200);
        q_addr  = 32'h44;
        q_cache = 1'b1;
        #1 check("t6_rely_other_word", rely, 16'h0000);
        rb = 1'b1;
        cycle();
        check("t6_occ_flush", occ, 0);
        check("t6_rely_flush", rely, 16'h0000);

        cycle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
